// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the CPU control sequencer: opcodes, ALU codes,
// sequencer states and instruction classes.
package cpu_ctrl_pkg;

  localparam int OPW  = 5;
  localparam int ALUW = 5;

  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_ROR  = 5'b00111;
  localparam logic [OPW-1:0] OP_ROL  = 5'b01000;
  localparam logic [OPW-1:0] OP_SHR  = 5'b01001;
  localparam logic [OPW-1:0] OP_SHRA = 5'b01010;
  localparam logic [OPW-1:0] OP_SHL  = 5'b01011;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  // ALU codes share the encoding of the reg-reg opcodes.
  localparam logic [ALUW-1:0] ALU_ADD = OP_ADD;
  localparam logic [ALUW-1:0] ALU_AND = OP_AND;
  localparam logic [ALUW-1:0] ALU_OR  = OP_OR;

  typedef enum logic [3:0] {
    ST_RST  = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_T7   = 4'd8,
    ST_HALT = 4'd9
  } state_e;

  typedef enum logic [2:0] {
    CL_ALU_RR  = 3'd0,
    CL_ALU_IMM = 3'd1,
    CL_LDI     = 3'd2,
    CL_LD      = 3'd3,
    CL_ST      = 3'd4,
    CL_NOP     = 3'd5,
    CL_HALT    = 3'd6,
    CL_ILLEGAL = 3'd7
  } iclass_e;

  function automatic logic is_alu_rr(input logic [OPW-1:0] op);
    return (op >= OP_ADD) && (op <= OP_SHL);
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Handshake between control_unit (master) and the datapath (slave):
// IR / memory status in, every control strobe out.
interface control_unit_if;
  import cpu_ctrl_pkg::*;

  logic [31:0]     IR;
  logic            Mem_ready;
  logic            Stop;
  logic            Start;
  logic            PCout, Zlowout, MDRout, BAout, Cout;
  logic            Rout, Rin, Gra, Grb, Grc;
  logic            MARin, MDRin, IRin, Yin, Zin, PCin, IncPC;
  logic            Read, Write;
  logic [ALUW-1:0] alu_op;
  logic            Run;
  logic            Illegal;

  modport master (
    input  IR, Mem_ready, Stop, Start,
    output PCout, Zlowout, MDRout, BAout, Cout, Rout, Rin, Gra, Grb, Grc,
           MARin, MDRin, IRin, Yin, Zin, PCin, IncPC, Read, Write,
           alu_op, Run, Illegal
  );

  modport slave (
    output IR, Mem_ready, Stop, Start,
    input  PCout, Zlowout, MDRout, BAout, Cout, Rout, Rin, Gra, Grb, Grc,
           MARin, MDRin, IRin, Yin, Zin, PCin, IncPC, Read, Write,
           alu_op, Run, Illegal
  );
endinterface

// File: rtl/opcode_decode.sv
// Combinational opcode classifier: instruction class plus the ALU code
// the execute phase should present.
module opcode_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [OPW-1:0]  opcode,
  output iclass_e         iclass,
  output logic [ALUW-1:0] alu_code
);

  // Class and ALU code lookup; anything unlisted is illegal.
  always_comb begin
    iclass   = CL_ILLEGAL;
    alu_code = '0;
    if (is_alu_rr(opcode)) begin
      iclass   = CL_ALU_RR;
      alu_code = opcode;
    end else begin
      case (opcode)
        OP_LD:   begin iclass = CL_LD;      alu_code = ALU_ADD; end
        OP_LDI:  begin iclass = CL_LDI;     alu_code = ALU_ADD; end
        OP_ST:   begin iclass = CL_ST;      alu_code = ALU_ADD; end
        OP_ADDI: begin iclass = CL_ALU_IMM; alu_code = ALU_ADD; end
        OP_ANDI: begin iclass = CL_ALU_IMM; alu_code = ALU_AND; end
        OP_ORI:  begin iclass = CL_ALU_IMM; alu_code = ALU_OR;  end
        OP_NOP:  iclass = CL_NOP;
        OP_HALT: iclass = CL_HALT;
        default: iclass = CL_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/control_unit.sv
// Moore sequencer for the bus-based CPU datapath: fetch, decode, execute
// and halt, with outputs decoded from state and the latched opcode.
module control_unit
  import cpu_ctrl_pkg::*;
(
  input  logic            Clock,
  input  logic            Resetn,
  control_unit_if.master  bus
);

  state_e          state_r, state_s;
  logic [OPW-1:0]  op_r, op_s;
  iclass_e         iclass_s;
  logic [ALUW-1:0] alu_code_s;
  state_e          done_s;
  logic            unused_ir_s;

  assign unused_ir_s = ^bus.IR[26:0];

  // IR only becomes valid in T3, so T3 decodes it live and later states use the copy.
  assign op_s = (state_r == ST_T3) ? bus.IR[31:27] : op_r;

  opcode_decode u_decode (
    .opcode   (op_s),
    .iclass   (iclass_s),
    .alu_code (alu_code_s)
  );

  // State register and opcode latch.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_r <= ST_RST;
      op_r    <= '0;
    end else begin
      state_r <= state_s;
      if (state_r == ST_T3) op_r <= bus.IR[31:27];
    end
  end

  // Next-state logic; Stop only diverts the edge that ends an instruction.
  always_comb begin
    done_s  = bus.Stop ? ST_HALT : ST_T0;
    state_s = state_r;
    case (state_r)
      ST_RST: state_s = ST_T0;
      ST_T0:  state_s = ST_T1;
      ST_T1:  state_s = bus.Mem_ready ? ST_T2 : ST_T1;
      ST_T2:  state_s = ST_T3;
      ST_T3: begin
        case (iclass_s)
          CL_HALT:             state_s = ST_HALT;
          CL_NOP, CL_ILLEGAL:  state_s = done_s;
          default:             state_s = ST_T4;
        endcase
      end
      ST_T4:  state_s = ST_T5;
      ST_T5: begin
        if (iclass_s == CL_LD || iclass_s == CL_ST) state_s = ST_T6;
        else                                        state_s = done_s;
      end
      ST_T6: begin
        if (iclass_s == CL_LD) state_s = bus.Mem_ready ? ST_T7 : ST_T6;
        else                   state_s = ST_T7;
      end
      ST_T7: begin
        if (iclass_s == CL_LD) state_s = done_s;
        else                   state_s = bus.Mem_ready ? done_s : ST_T7;
      end
      ST_HALT: begin
        if (bus.Start && !bus.Stop) state_s = ST_T0;
        else                        state_s = ST_HALT;
      end
      default: state_s = ST_RST;
    endcase
  end

  // Strobe decode from state and instruction class.
  always_comb begin
    bus.PCout = 1'b0; bus.Zlowout = 1'b0; bus.MDRout = 1'b0; bus.BAout = 1'b0;
    bus.Cout  = 1'b0; bus.Rout = 1'b0; bus.Rin = 1'b0;
    bus.Gra   = 1'b0; bus.Grb = 1'b0; bus.Grc = 1'b0;
    bus.MARin = 1'b0; bus.MDRin = 1'b0; bus.IRin = 1'b0; bus.Yin = 1'b0;
    bus.Zin   = 1'b0; bus.PCin = 1'b0; bus.IncPC = 1'b0;
    bus.Read  = 1'b0; bus.Write = 1'b0;
    bus.alu_op  = '0;
    bus.Illegal = 1'b0;
    bus.Run = (state_r != ST_RST) && (state_r != ST_HALT);
    case (state_r)
      ST_T0: begin bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1; end
      ST_T1: begin bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1; end
      ST_T2: begin bus.MDRout = 1'b1; bus.IRin = 1'b1; end
      ST_T3: begin
        case (iclass_s)
          CL_ALU_RR, CL_ALU_IMM: begin bus.Grb = 1'b1; bus.Rout = 1'b1;  bus.Yin = 1'b1; end
          CL_LDI, CL_LD, CL_ST:  begin bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1; end
          CL_ILLEGAL:            bus.Illegal = 1'b1;
          default:               bus.Illegal = 1'b0;
        endcase
      end
      ST_T4: begin
        bus.Zin    = 1'b1;
        bus.alu_op = alu_code_s;
        if (iclass_s == CL_ALU_RR) begin bus.Grc = 1'b1; bus.Rout = 1'b1; end
        else                       bus.Cout = 1'b1;
      end
      ST_T5: begin
        bus.Zlowout = 1'b1;
        if (iclass_s == CL_LD || iclass_s == CL_ST) bus.MARin = 1'b1;
        else begin bus.Gra = 1'b1; bus.Rin = 1'b1; end
      end
      ST_T6: begin
        bus.MDRin = 1'b1;
        if (iclass_s == CL_LD) bus.Read = 1'b1;
        else begin bus.Gra = 1'b1; bus.Rout = 1'b1; end
      end
      ST_T7: begin
        if (iclass_s == CL_LD) begin bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
        else                   bus.Write = 1'b1;
      end
      default: bus.Run = bus.Run;
    endcase
  end

endmodule
